// File: rtl/reg_file_32.sv
// reg_file_32: 32-entry x 32-bit register file, two registered read ports, one write port.
// Register 0 is hardwired to zero. Read data is registered (1-cycle latency) and
// qualified by a one-cycle rd_valid strobe.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset; clears storage and read outputs
//   rd_en    - read request, samples ra1/ra2 on the rising edge
//   ra1/ra2  - read addresses (operand A / operand B)
//   rd1/rd2  - registered read data; held while no read is accepted
//   rd_valid - high for one cycle after each accepted read
//   we/wa/wd - write enable, address and data; writes to address 0 are dropped
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, a read on the same edge as a write to the same
//                       nonzero address returns the new write data (write-first).
//                       When undefined, the read returns the pre-write value (read-first).
module reg_file_32 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rd1_d, rd1_q;
  logic [DATA_W-1:0] rd2_d, rd2_q;
  logic              rd_valid_q;
  logic              wr_en;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end

  // Read mux. Address 0 is forced to zero explicitly; the bypass compare cannot
  // fire for address 0 because wr_en already excludes it.
  always_comb begin
    rd1_d = (ra1 == '0) ? '0 : mem_q[ra1];
    rd2_d = (ra2 == '0) ? '0 : mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wa == ra1)) rd1_d = wd;
    if (wr_en && (wa == ra2)) rd2_d = wd;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
    end
  end

  assign rd1      = rd1_q;
  assign rd2      = rd2_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_32.sv
// tb_reg_file_32: self-checking bench for reg_file_32.
// A reference array tracks register contents; each issued read pushes its expected
// operand pair onto a scoreboard queue, popped and compared when rd_valid is due.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_reg_file_32;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rd1, rd2;
  logic          rd_valid;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[32];
  int            passed = 0;
  int            total  = 0;

  always #5 clk = ~clk;

  reg_file_32 #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .rd_valid(rd_valid),
    .we      (we),
    .wa      (wa),
    .wd      (wd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    sb.delete();
  endtask

  // Value a read of address a returns on the coming edge, given the current write inputs.
  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && (wa == a)) return wd;
`endif
    return model[a];
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick();
    we = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  task automatic issue_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_en = 1'b1;
    ra1   = a1;
    ra2   = a2;
    sb.push_back({rd_val(a1), rd_val(a2)});
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    #3;
    total++;
    if ({rd_valid, rd1, rd2} !== '0)
      $display("FAIL reset_init: got v=%b rd1=%h rd2=%h, want all 0", rd_valid, rd1, rd2);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    tick();

    wr(5, 32'hDEAD_BEEF);
    issue_rd(5, 5);
    tick();
    e = sb.pop_front();
    total++;
    if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1)
      $display("FAIL reset_preread: got v=%b rd1=%h rd2=%h, want v=1 rd1=%h rd2=%h",
               rd_valid, rd1, rd2, e.a, e.b);
    else passed++;

    // Read for r5 still requested; reset lands mid-cycle and must act at once.
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rd1 !== '0 || rd2 !== '0 || rd_valid !== 1'b0)
      $display("FAIL reset_async: got v=%b rd1=%h rd2=%h, want all 0", rd_valid, rd1, rd2);
    else passed++;
    clear_model();
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd1 !== '0)
      $display("FAIL reset_inflight: got v=%b rd1=%h, want v=0 rd1=0", rd_valid, rd1);
    else passed++;
    rst = 1'b0;
    issue_rd(5, 0);
    tick();
    rd_en = 1'b0;
    e = sb.pop_front();
    total++;
    if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1 || rd1 !== 32'h0)
      $display("FAIL reset_cleared: got v=%b rd1=%h rd2=%h, want v=1 rd1=0 rd2=0",
               rd_valid, rd1, rd2);
    else passed++;
    tick();
  endtask

  task automatic test_basic_read();
    exp_t e;
    wr(3, 32'h0000_00F0);
    wr(7, 32'h0000_0FF0);
    issue_rd(3, 7);
    tick();
    rd_en = 1'b0;
    e = sb.pop_front();
    total++;
    if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1 || rd1 !== 32'h0000_00F0)
      $display("FAIL basic_read: got v=%b rd1=%h rd2=%h, want v=1 rd1=%h rd2=%h",
               rd_valid, rd1, rd2, e.a, e.b);
    else passed++;
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd1 !== e.a || rd2 !== e.b)
      $display("FAIL basic_hold: got v=%b rd1=%h rd2=%h, want v=0 rd1=%h rd2=%h",
               rd_valid, rd1, rd2, e.a, e.b);
    else passed++;
  endtask

  task automatic test_zero_reg();
    exp_t e;
    // Write to r0 on the same edge as a read of r0.
    we = 1'b1;
    wa = '0;
    wd = 32'hFFFF_FFFF;
    issue_rd(0, 0);
    tick();
    we = 1'b0;
    e = sb.pop_front();
    total++;
    if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1 || rd1 !== 32'h0)
      $display("FAIL zero_same_edge: got v=%b rd1=%h rd2=%h, want v=1 rd1=0 rd2=0",
               rd_valid, rd1, rd2);
    else passed++;
    issue_rd(0, 0);
    tick();
    rd_en = 1'b0;
    e = sb.pop_front();
    total++;
    if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1)
      $display("FAIL zero_later: got v=%b rd1=%h rd2=%h, want v=1 rd1=0 rd2=0",
               rd_valid, rd1, rd2);
    else passed++;
    tick();
  endtask

  task automatic test_collision();
    exp_t e;
    logic [DW-1:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h2222_2222;
`else
    want = 32'h1111_1111;
`endif
    wr(9, 32'h1111_1111);
    we = 1'b1;
    wa = 9;
    wd = 32'h2222_2222;
    issue_rd(9, 9);
    tick();
    we = 1'b0;
    model[9] = 32'h2222_2222;
    e = sb.pop_front();
    total++;
    if (rd1 !== want || rd2 !== want || e.a !== want || rd_valid !== 1'b1)
      $display("FAIL collision_same_edge: got v=%b rd1=%h rd2=%h, want v=1 rd1=rd2=%h",
               rd_valid, rd1, rd2, want);
    else passed++;
    issue_rd(9, 0);
    tick();
    rd_en = 1'b0;
    e = sb.pop_front();
    total++;
    if (rd1 !== 32'h2222_2222 || rd2 !== e.b || rd_valid !== 1'b1)
      $display("FAIL collision_next: got v=%b rd1=%h rd2=%h, want v=1 rd1=22222222 rd2=0",
               rd_valid, rd1, rd2);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 1; i <= 4; i++) wr(AW'(i), DW'(32'hA0 + i));
    for (int i = 1; i <= 4; i++) begin
      issue_rd(AW'(i), AW'(5 - i));
      tick();
      e = sb.pop_front();
      total++;
      if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1 || rd1 !== DW'(32'hA0 + i))
        $display("FAIL stream_%0d: got v=%b rd1=%h rd2=%h, want v=1 rd1=%h rd2=%h",
                 i, rd_valid, rd1, rd2, e.a, e.b);
      else passed++;
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd1 !== 32'hA4)
      $display("FAIL stream_end: got v=%b rd1=%h, want v=0 rd1=000000a4", rd_valid, rd1);
    else passed++;
  endtask

  task automatic test_sweep();
    exp_t e;
    int   errs = 0;
    for (int i = 1; i < 32; i++) wr(AW'(i), DW'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      issue_rd(AW'(i), AW'(31 - i));
      tick();
      e = sb.pop_front();
      total++;
      if (rd1 !== e.a || rd2 !== e.b || rd_valid !== 1'b1) begin
        $display("FAIL sweep_%0d: got v=%b rd1=%h rd2=%h, want v=1 rd1=%h rd2=%h",
                 i, rd_valid, rd1, rd2, e.a, e.b);
        errs++;
      end else passed++;
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (sb.size() != 0 || rd_valid !== 1'b0)
      $display("FAIL sweep_drain: got queue=%0d v=%b, want queue=0 v=0", sb.size(), rd_valid);
    else passed++;
  endtask

  initial begin
    rst   = 1'b1;
    rd_en = 1'b0;
    ra1   = '0;
    ra2   = '0;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;
    clear_model();
    test_reset();
    test_basic_read();
    test_zero_reg();
    test_collision();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
